uart_cmd_queue: RTL and testbench

Command buffer that sits directly upstream of the UART transmit path. It accepts CMD_WIDTH-bit commands from the host/control logic and holds them in a FIFO. It presents the commands to the UART over the cmd_out / cmd_vld / cmd_rdy handshake, so bursts of host commands are not lost while the UART is busy serialising. It also provides fill-level, full/almost-full and sticky-overflow status.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_cmd_queue_if.sv | 33 +++
 rtl/uart_cmd_ram.sv | 28 ++
 rtl/uart_cmd_queue.sv | 94 +++++++++
 tb/tb_uart_cmd_queue.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART command queue: default command width,
// command word type and the level-counter width helper.
package uart_pkg;

  localparam int DEF_CMD_WIDTH = 16;

  typedef logic [DEF_CMD_WIDTH-1:0] cmd_t;

  // Level must represent 0..depth inclusive, hence depth+1 codes.
  function automatic int level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/uart_cmd_queue_if.sv
// Host-push / UART-pop handshake bundle for the command queue.
// The queue uses the slave modport; the host/UART side uses the master modport.
interface uart_cmd_queue_if
  import uart_pkg::*;
#(
  parameter int CMD_WIDTH = DEF_CMD_WIDTH,
  parameter int DEPTH     = 8
) ();

  localparam int LW = level_w(DEPTH);

  logic                 wr_en;
  logic [CMD_WIDTH-1:0] wr_data;
  logic                 full;
  logic                 afull;
  logic [LW-1:0]        level;
  logic                 overflow;
  logic                 clr_ovf;
  logic [CMD_WIDTH-1:0] cmd_out;
  logic                 cmd_vld;
  logic                 cmd_rdy;

  modport slave (
    input  wr_en, wr_data, clr_ovf, cmd_rdy,
    output full, afull, level, overflow, cmd_out, cmd_vld
  );

  modport master (
    output wr_en, wr_data, clr_ovf, cmd_rdy,
    input  full, afull, level, overflow, cmd_out, cmd_vld
  );

endinterface

// File: rtl/uart_cmd_ram.sv
// Command storage: synchronous write, asynchronous read at the head pointer.
// Contents are intentionally not reset; validity is tracked by the level counter.
module uart_cmd_ram
  import uart_pkg::*;
#(
  parameter int CMD_WIDTH = DEF_CMD_WIDTH,
  parameter int DEPTH     = 8,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [CMD_WIDTH-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic [CMD_WIDTH-1:0] rdata
);

  logic [CMD_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_cmd_queue.sv
// First-word-fall-through command queue in front of the UART transmitter,
// with registered full/afull and a sticky overflow flag.
module uart_cmd_queue
  import uart_pkg::*;
#(
  parameter int CMD_WIDTH   = DEF_CMD_WIDTH,
  parameter int DEPTH       = 8,
  parameter int AFULL_LEVEL = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_cmd_queue_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AFULL = LW'(AFULL_LEVEL);

  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q,  level_d;
  logic                 full_q,   full_d;
  logic                 afull_q,  afull_d;
  logic                 ovf_q,    ovf_d;
  logic                 push, pop, drop;
  logic [CMD_WIDTH-1:0] rd_data;

  // full_q is the pre-edge state, so a push at full is dropped even if a pop
  // frees a slot on the same edge.
  always_comb begin
    push     = bus.wr_en && !full_q;
    drop     = bus.wr_en &&  full_q;
    pop      = (level_q != '0) && bus.cmd_rdy;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    full_d  = (level_d == LVL_FULL);
    afull_d = (level_d >= LVL_AFULL);

    // A drop in the same cycle as a clear must leave the flag set.
    if (bus.clr_ovf) ovf_d = 1'b0;
    if (drop)        ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
    end
  end

  uart_cmd_ram #(
    .CMD_WIDTH (CMD_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (bus.wr_data),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign bus.cmd_vld  = (level_q != '0);
  assign bus.cmd_out  = rd_data;
  assign bus.level    = level_q;
  assign bus.full     = full_q;
  assign bus.afull    = afull_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_uart_cmd_queue.sv
// Directed and randomized checks of uart_cmd_queue against a queue-based
// reference model of the command buffer.
module tb_uart_cmd_queue;
  import uart_pkg::*;

  localparam int DEPTH = 8;
  localparam int AFULL = 6;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  uart_cmd_queue_if #(.CMD_WIDTH(DEF_CMD_WIDTH), .DEPTH(DEPTH)) bus ();

  uart_cmd_queue #(
    .CMD_WIDTH   (DEF_CMD_WIDTH),
    .DEPTH       (DEPTH),
    .AFULL_LEVEL (AFULL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  cmd_t mq[$];
  bit   movf;
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_chk  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".vld"},   32'(bus.cmd_vld),  32'(mq.size() != 0));
    if (mq.size() != 0) check({tag, ".out"}, 32'(bus.cmd_out), 32'(mq[0]));
    check({tag, ".level"}, 32'(bus.level),    32'(mq.size()));
    check({tag, ".full"},  32'(bus.full),     32'(mq.size() == DEPTH));
    check({tag, ".afull"}, 32'(bus.afull),    32'(mq.size() >= AFULL));
    check({tag, ".ovf"},   32'(bus.overflow), 32'(movf));
  endtask

  // One clock: drive inputs, apply the reference rules with pre-edge state,
  // then compare just after the edge.
  task automatic step(input bit wr, input cmd_t d, input bit rdy, input bit clr, input string tag);
    bit full_pre, do_push, do_pop;
    bus.wr_en   = wr;
    bus.wr_data = d;
    bus.cmd_rdy = rdy;
    bus.clr_ovf = clr;
    @(posedge clk);
    full_pre = (mq.size() == DEPTH);
    do_push  = wr && !full_pre;
    do_pop   = (mq.size() != 0) && rdy;
    if (do_pop)  void'(mq.pop_front());
    if (do_push) mq.push_back(d);
    if (wr && full_pre) movf = 1'b1;
    else if (clr)       movf = 1'b0;
    #1;
    check_all(tag);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i <= DEPTH && mq.size() != 0; i++) step(1'b0, '0, 1'b1, 1'b0, tag);
    check({tag, ".empty"}, 32'(bus.level), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.cmd_rdy = 1'b0;
    bus.clr_ovf = 1'b0;
    movf        = 1'b0;
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single push, hold, pop
    step(1'b1, 16'hA55A, 1'b0, 1'b0, "t1_push");
    check("t1_out", 32'(bus.cmd_out), 32'h0000A55A);
    for (int i = 0; i < 5; i++) step(1'b0, cmd_t'($urandom), 1'b0, 1'b0, "t1_hold");
    step(1'b0, '0, 1'b1, 1'b0, "t1_pop");

    // Fill past full, then drain in order
    for (int i = 1; i <= 9; i++) step(1'b1, cmd_t'(i), 1'b0, 1'b0, "t2_fill");
    check("t2_ovf_set", 32'(bus.overflow), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      check("t2_order", 32'(bus.cmd_out), 32'(i));
      step(1'b0, '0, 1'b1, 1'b0, "t2_drain");
    end
    step(1'b0, '0, 1'b0, 1'b1, "t2_clr");

    // Simultaneous push/pop at level 3, then at full
    for (int i = 0; i < 3; i++) step(1'b1, cmd_t'($urandom), 1'b0, 1'b0, "t3_pre");
    for (int i = 0; i < 10; i++) step(1'b1, cmd_t'($urandom), 1'b1, 1'b0, "t3_pp");
    for (int i = 0; i < 5; i++) step(1'b1, cmd_t'($urandom), 1'b0, 1'b0, "t3_fill");
    step(1'b1, 16'hDEAD, 1'b1, 1'b0, "t3_full_pp");
    check("t3_full_lvl", 32'(bus.level), 32'd7);

    // Clear vs drop priority
    step(1'b1, cmd_t'($urandom), 1'b0, 1'b0, "t5_refill");
    step(1'b1, cmd_t'($urandom), 1'b0, 1'b1, "t5_clr_drop");
    check("t5_ovf_kept", 32'(bus.overflow), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1, "t5_clr");
    check("t5_ovf_clr", 32'(bus.overflow), 32'd0);

    // Random traffic across several pointer wraps
    drain("t4_pre");
    for (int i = 0; i < 12 * DEPTH; i++)
      step(1'($urandom_range(0, 1)), cmd_t'($urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), "t4_rand");
    drain("t4_post");

    // Async reset mid-burst with overflow set
    for (int i = 0; i < 9; i++) step(1'b1, cmd_t'($urandom), 1'b0, 1'b0, "t6_fill");
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, "t6_pop");
    check("t6_lvl5", 32'(bus.level), 32'd5);
    @(negedge clk);
    bus.wr_en   = 1'b0;
    bus.cmd_rdy = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete();
    movf = 1'b0;
    check_all("t6_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 16'hBEEF, 1'b0, 1'b0, "t6_beef");
    check("t6_beef_out", 32'(bus.cmd_out), 32'h0000BEEF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
